// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the IR / memory / ALU datapath.
// master = sequencer side (drives strobes and selects), slave = datapath side.
interface multicycle_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             zero;
    logic             mem_ready;

    logic             pc_write;
    logic             adr_src;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, trap, trap_cause, instret
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, trap, trap_cause, instret
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// RV32I multicycle sequencer: Moore strobes per state, 3-5 cycles per instruction with mem_ready tied high.
// Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready; traps (sticky) on illegal op or memory timeout.
module multicycle_control_fsm #(
    parameter bit SUPPORT_JUMP = 1'b1,
    parameter bit SUPPORT_BNE  = 1'b1,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_fsm_if.master    bus
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        cause_q;
    logic [1:0]        cause_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  instret_q;

    logic              in_wait_state;
    logic              timed_out;
    logic              retire;

    logic              pc_write;
    logic              adr_src;
    logic              mem_read;
    logic              mem_write;
    logic              ir_write;
    logic              reg_write;
    logic [1:0]        result_src;
    logic [1:0]        alu_src_a;
    logic [1:0]        alu_src_b;
    logic [1:0]        alu_op;

    assign in_wait_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timed_out     = (wait_cnt == WAIT_LIMIT);

    // mem_ready takes priority over the timeout in every waiting state.
    always_comb begin
        state_nxt  = state;
        cause_nxt  = cause_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;

        unique case (state)
            S_BOOT: begin
                state_nxt = S_FETCH;
            end

            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (bus.mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timed_out) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end

            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.opcode)
                    OP_LOAD,
                    OP_STORE:  state_nxt = S_MEMADR;
                    OP_RTYPE:  state_nxt = S_EXECR;
                    OP_ITYPE:  state_nxt = S_EXECI;
                    OP_BRANCH: state_nxt = S_BRANCH;
                    OP_JAL: begin
                        if (SUPPORT_JUMP) begin
                            state_nxt = S_JAL;
                        end else begin
                            state_nxt = S_TRAP;
                            cause_nxt = CAUSE_ILLEGAL;
                        end
                    end
                    default: begin
                        state_nxt = S_TRAP;
                        cause_nxt = CAUSE_ILLEGAL;
                    end
                endcase
            end

            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    state_nxt = S_MEMWB;
                end else if (timed_out) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end

            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end

            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready) begin
                    state_nxt = S_FETCH;
                end else if (timed_out) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end

            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end

            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end

            S_ALUWB: begin
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                if (bus.funct3 == 3'b000) begin
                    pc_write  = bus.zero;
                    state_nxt = S_FETCH;
                end else if ((bus.funct3 == 3'b001) && SUPPORT_BNE) begin
                    pc_write  = !bus.zero;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end
            end

            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_nxt = S_ALUWB;
            end

            S_TRAP: begin
                state_nxt = S_TRAP;
            end

            default: begin
                state_nxt = S_BOOT;
                cause_nxt = CAUSE_NONE;
            end
        endcase
    end

    assign retire = (state_nxt == S_FETCH) &&
                    ((state == S_MEMWB) || (state == S_MEMWRITE) ||
                     (state == S_ALUWB) || (state == S_BRANCH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_BOOT;
            cause_q <= CAUSE_NONE;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
        end
    end

    // Any state change re-arms the wait counter, so it always starts at 0 on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            wait_cnt <= '0;
        end else if (in_wait_state && !bus.mem_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign bus.pc_write   = pc_write;
    assign bus.adr_src    = adr_src;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.reg_write  = reg_write;
    assign bus.result_src = result_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.trap       = (state == S_TRAP);
    assign bus.trap_cause = cause_q;
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: default build, a JAL/BNE-less build, and a short-timeout/3-bit-counter build.
module tb_multicycle_control_fsm;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] IM = 7'b0010011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] JL = 7'b1101111;

    // {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, alu_op, trap, trap_cause}
    localparam logic [16:0] C_BOOT   = 17'b0;
    localparam logic [16:0] C_FET_R  = 17'b1_0_1_0_1_0_10_00_10_00_0_00;
    localparam logic [16:0] C_FET_W  = 17'b0_0_1_0_0_0_10_00_10_00_0_00;
    localparam logic [16:0] C_DEC    = 17'b0_0_0_0_0_0_00_01_01_00_0_00;
    localparam logic [16:0] C_MADR   = 17'b0_0_0_0_0_0_00_10_01_00_0_00;
    localparam logic [16:0] C_MRD    = 17'b0_1_1_0_0_0_00_00_00_00_0_00;
    localparam logic [16:0] C_MWB    = 17'b0_0_0_0_0_1_01_00_00_00_0_00;
    localparam logic [16:0] C_MWR    = 17'b0_1_0_1_0_0_00_00_00_00_0_00;
    localparam logic [16:0] C_EXR    = 17'b0_0_0_0_0_0_00_10_00_10_0_00;
    localparam logic [16:0] C_EXI    = 17'b0_0_0_0_0_0_00_10_01_10_0_00;
    localparam logic [16:0] C_AWB    = 17'b0_0_0_0_0_1_00_00_00_00_0_00;
    localparam logic [16:0] C_BR_T   = 17'b1_0_0_0_0_0_00_10_00_01_0_00;
    localparam logic [16:0] C_BR_N   = 17'b0_0_0_0_0_0_00_10_00_01_0_00;
    localparam logic [16:0] C_JAL    = 17'b1_0_0_0_0_0_00_01_10_00_0_00;
    localparam logic [16:0] C_TRAP1  = 17'b0_0_0_0_0_0_00_00_00_00_1_01;
    localparam logic [16:0] C_TRAP2  = 17'b0_0_0_0_0_0_00_00_00_00_1_10;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        z;
        logic        mr;
        logic [16:0] ctl;
        logic [31:0] ir;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.CNT_W(32)) bus0 ();
    multicycle_control_fsm_if #(.CNT_W(32)) bus1 ();
    multicycle_control_fsm_if #(.CNT_W(3))  bus2 ();

    multicycle_control_fsm #(.SUPPORT_JUMP(1'b1), .SUPPORT_BNE(1'b1), .MEM_TIMEOUT(16), .CNT_W(32))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    multicycle_control_fsm #(.SUPPORT_JUMP(1'b0), .SUPPORT_BNE(1'b0), .MEM_TIMEOUT(16), .CNT_W(32))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    multicycle_control_fsm #(.SUPPORT_JUMP(1'b1), .SUPPORT_BNE(1'b1), .MEM_TIMEOUT(4), .CNT_W(3))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [16:0] ctl0, ctl1, ctl2;
    assign ctl0 = {bus0.pc_write, bus0.adr_src, bus0.mem_read, bus0.mem_write, bus0.ir_write, bus0.reg_write,
                   bus0.result_src, bus0.alu_src_a, bus0.alu_src_b, bus0.alu_op, bus0.trap, bus0.trap_cause};
    assign ctl1 = {bus1.pc_write, bus1.adr_src, bus1.mem_read, bus1.mem_write, bus1.ir_write, bus1.reg_write,
                   bus1.result_src, bus1.alu_src_a, bus1.alu_src_b, bus1.alu_op, bus1.trap, bus1.trap_cause};
    assign ctl2 = {bus2.pc_write, bus2.adr_src, bus2.mem_read, bus2.mem_write, bus2.ir_write, bus2.reg_write,
                   bus2.result_src, bus2.alu_src_a, bus2.alu_src_b, bus2.alu_op, bus2.trap, bus2.trap_cause};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic mr);
        bus0.opcode = op; bus0.funct3 = f3; bus0.zero = z; bus0.mem_ready = mr;
        bus1.opcode = op; bus1.funct3 = f3; bus1.zero = z; bus1.mem_ready = mr;
        bus2.opcode = op; bus2.funct3 = f3; bus2.zero = z; bus2.mem_ready = mr;
    endtask

    // Next cycle: drive its inputs just after the edge, then stop at the negedge to sample.
    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic mr);
        @(posedge clk);
        #1;
        drive(op, f3, z, mr);
        @(negedge clk);
    endtask

    // Leaves the bench just after a rising edge with reset released; the current cycle is BOOT.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(R, 3'b000, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic mr,
                       input logic [16:0] ctl, input logic [31:0] ir);
        vec_t v;
        v.op = op; v.f3 = f3; v.z = z; v.mr = mr; v.ctl = ctl; v.ir = ir;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t e;

        // One row per cycle on the default build, starting in the BOOT cycle after reset.
        add(R,  3'b000, 1'b0, 1'b1, C_BOOT,  0);
        add(R,  3'b000, 1'b0, 1'b1, C_FET_R, 0);
        add(R,  3'b000, 1'b0, 1'b1, C_DEC,   0);
        add(R,  3'b000, 1'b0, 1'b1, C_EXR,   0);
        add(R,  3'b000, 1'b0, 1'b1, C_AWB,   0);
        add(LD, 3'b010, 1'b0, 1'b0, C_FET_W, 1);
        add(LD, 3'b010, 1'b0, 1'b1, C_FET_R, 1);
        add(LD, 3'b010, 1'b0, 1'b0, C_DEC,   1);
        add(LD, 3'b010, 1'b0, 1'b1, C_MADR,  1);
        add(LD, 3'b010, 1'b0, 1'b0, C_MRD,   1);
        add(LD, 3'b010, 1'b0, 1'b0, C_MRD,   1);
        add(LD, 3'b010, 1'b0, 1'b0, C_MRD,   1);
        add(LD, 3'b010, 1'b0, 1'b1, C_MRD,   1);
        add(LD, 3'b010, 1'b0, 1'b1, C_MWB,   1);
        add(BR, 3'b000, 1'b1, 1'b1, C_FET_R, 2);
        add(BR, 3'b000, 1'b1, 1'b1, C_DEC,   2);
        add(BR, 3'b000, 1'b1, 1'b1, C_BR_T,  2);
        add(BR, 3'b001, 1'b1, 1'b1, C_FET_R, 3);
        add(BR, 3'b001, 1'b1, 1'b1, C_DEC,   3);
        add(BR, 3'b001, 1'b1, 1'b1, C_BR_N,  3);
        add(ST, 3'b010, 1'b0, 1'b1, C_FET_R, 4);
        add(ST, 3'b010, 1'b0, 1'b1, C_DEC,   4);
        add(ST, 3'b010, 1'b0, 1'b1, C_MADR,  4);
        add(ST, 3'b010, 1'b0, 1'b1, C_MWR,   4);
        add(IM, 3'b000, 1'b0, 1'b1, C_FET_R, 5);
        add(IM, 3'b000, 1'b0, 1'b1, C_DEC,   5);
        add(IM, 3'b000, 1'b0, 1'b1, C_EXI,   5);
        add(IM, 3'b000, 1'b0, 1'b1, C_AWB,   5);
        add(JL, 3'b000, 1'b0, 1'b1, C_FET_R, 6);
        add(JL, 3'b000, 1'b0, 1'b1, C_DEC,   6);
        add(JL, 3'b000, 1'b0, 1'b1, C_JAL,   6);
        add(JL, 3'b000, 1'b0, 1'b1, C_AWB,   6);
        add(BR, 3'b010, 1'b1, 1'b1, C_FET_R, 7);
        add(BR, 3'b010, 1'b1, 1'b1, C_DEC,   7);
        add(BR, 3'b010, 1'b1, 1'b1, C_BR_N,  7);
        add(BR, 3'b010, 1'b1, 1'b1, C_TRAP1, 7);
        add(BR, 3'b000, 1'b0, 1'b1, C_TRAP1, 7);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            drive(vecs[i].op, vecs[i].f3, vecs[i].z, vecs[i].mr);
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("vec%0d ctl", i), 32'(ctl0), 32'(e.ctl));
            check($sformatf("vec%0d instret", i), bus0.instret, e.ir);
        end

        // Reset asserted mid-cycle during a stalled store must drop mem_write at once.
        do_reset();
        @(negedge clk);
        step(R,  3'b000, 1'b0, 1'b1);
        step(R,  3'b000, 1'b0, 1'b1);
        step(R,  3'b000, 1'b0, 1'b1);
        step(R,  3'b000, 1'b0, 1'b1);
        step(ST, 3'b010, 1'b0, 1'b1);
        step(ST, 3'b010, 1'b0, 1'b1);
        step(ST, 3'b010, 1'b0, 1'b1);
        step(ST, 3'b010, 1'b0, 1'b0);
        check("memwrite before reset", 32'(ctl0), 32'(C_MWR));
        check("instret before reset", bus0.instret, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset ctl", 32'(ctl0), 32'(C_BOOT));
        check("async reset mem_write", 32'(bus0.mem_write), 32'd0);
        check("async reset instret", bus0.instret, 32'd0);

        // JAL with jumps disabled: illegal trap, absorbing, cleared by reset.
        do_reset();
        @(negedge clk);
        check("nojal boot", 32'(ctl1), 32'(C_BOOT));
        step(JL, 3'b000, 1'b0, 1'b1);
        check("nojal fetch", 32'(ctl1), 32'(C_FET_R));
        step(JL, 3'b000, 1'b0, 1'b1);
        check("nojal decode", 32'(ctl1), 32'(C_DEC));
        for (int k = 0; k < 20; k++) begin
            step(JL, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check($sformatf("nojal trap hold %0d", k), 32'(ctl1), 32'(C_TRAP1));
        end
        #1 rst_n = 1'b0;
        #1;
        check("nojal reset clears", 32'(ctl1), 32'(C_BOOT));

        // BNE with SUPPORT_BNE=0: no PC write even though !zero, then illegal trap.
        do_reset();
        @(negedge clk);
        step(BR, 3'b001, 1'b0, 1'b1);
        step(BR, 3'b001, 1'b0, 1'b1);
        step(BR, 3'b001, 1'b0, 1'b1);
        check("nobne branch", 32'(ctl1), 32'(C_BR_N));
        step(BR, 3'b001, 1'b0, 1'b1);
        check("nobne trap", 32'(ctl1), 32'(C_TRAP1));
        check("nobne instret", bus1.instret, 32'd0);

        // MEM_TIMEOUT=4: four stalled FETCH cycles, then timeout trap.
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            step(R, 3'b000, 1'b0, 1'b0);
            check($sformatf("timeout fetch %0d", k), 32'(ctl2), 32'(C_FET_W));
        end
        step(R, 3'b000, 1'b0, 1'b0);
        check("timeout trap", 32'(ctl2), 32'(C_TRAP2));
        check("timeout mem_read", 32'(bus2.mem_read), 32'd0);

        // mem_ready arriving on the limit cycle wins over the timeout.
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) step(R, 3'b000, 1'b0, 1'b0);
        step(R, 3'b000, 1'b0, 1'b1);
        check("limit ready fetch", 32'(ctl2), 32'(C_FET_R));
        step(R, 3'b000, 1'b0, 1'b0);
        check("limit ready decode", 32'(ctl2), 32'(C_DEC));

        // 3-bit instret wraps after 8 retirements.
        do_reset();
        @(negedge clk);
        step(R, 3'b000, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            repeat (4) step(R, 3'b000, 1'b0, 1'b1);
            check($sformatf("wrap instret %0d", k), 32'(bus2.instret), 32'(k % 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
